// File: rtl/stream_widen_nto32_pkg.sv
// Shared constants for the narrow-to-256-bit widening buffer: stream geometry
// and the slot-count helper used to size the write pointer.
package stream_pkg;

    localparam int STREAM_BYTES = 32;
    localparam int BUFFER_BYTES = 96;
    localparam int SEGMENTS     = 3;

    typedef logic [1:0] seg_idx_t;

    function automatic int slots(input int in_words);
        return BUFFER_BYTES / in_words;
    endfunction

endpackage

// File: rtl/stream_widen_nto32_if.sv
// Valid/ready bundle for the widening buffer: narrow input stream plus 256-bit output stream.
interface stream_widen_nto32_if #(
    parameter int IN_WIDTH = 48
);
    logic [IN_WIDTH-1:0] stream_in;
    logic                stream_in_valid;
    logic                stream_in_ready;
    logic [255:0]        stream_out;
    logic                stream_out_valid;
    logic                stream_out_ready;

    modport slave (
        input  stream_in,
        input  stream_in_valid,
        output stream_in_ready,
        output stream_out,
        output stream_out_valid,
        input  stream_out_ready
    );

    modport master (
        output stream_in,
        output stream_in_valid,
        input  stream_in_ready,
        input  stream_out,
        input  stream_out_valid,
        output stream_out_ready
    );
endinterface

// File: rtl/stream_widen_nto32.sv
// Packs IN_WORDS-byte beats into 32-byte beats through a 96-byte circular buffer
// with per-byte occupancy flags and a single registered output stage.
module stream_widen_nto32
    import stream_pkg::*;
#(
    parameter int IN_WORDS = 6,
    parameter int SB_WIDTH = slots(IN_WORDS),
    parameter int WR_WIDTH = (SB_WIDTH > 1) ? $clog2(SB_WIDTH) : 1,
    parameter int IN_WIDTH = IN_WORDS * 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    stream_widen_nto32_if.slave   bus
);

    generate
        if (IN_WORDS < 1 || IN_WORDS > STREAM_BYTES || (BUFFER_BYTES % IN_WORDS) != 0) begin : g_bad_in_words
            $error("stream_widen_nto32: IN_WORDS must divide 96 and be <= 32");
        end
    endgenerate

    logic [8*BUFFER_BYTES-1:0] buffer_q, buffer_d;
    logic [BUFFER_BYTES-1:0]   used_q, used_d, byte_set, byte_clr;
    logic [WR_WIDTH-1:0]       wr_ptr_q, wr_ptr_d;
    seg_idx_t                  rd_seg_q, rd_seg_d;
    logic [8*STREAM_BYTES-1:0] out_q, out_d, seg_data;
    logic                      out_valid_q, out_valid_d;
    logic                      in_ready, wr_fire, seg_full, rd_load;

    // A slot is writable only when every byte it covers is free, so a slot
    // straddling two segments waits until both have been drained.
    assign in_ready = rst_n && (used_q[IN_WORDS*wr_ptr_q +: IN_WORDS] == '0);
    assign wr_fire  = bus.stream_in_valid && in_ready;
    assign rd_load  = (!out_valid_q || bus.stream_out_ready) && seg_full;

    always_comb begin
        seg_full = 1'b0;
        seg_data = '0;
        for (int g = 0; g < SEGMENTS; g++) begin
            if (rd_seg_q == seg_idx_t'(g)) begin
                seg_full = &used_q[STREAM_BYTES*g +: STREAM_BYTES];
                seg_data = buffer_q[8*STREAM_BYTES*g +: 8*STREAM_BYTES];
            end
        end
    end

    // Per-byte write/clear decode; set and clear never hit the same byte.
    generate
        for (genvar gi = 0; gi < BUFFER_BYTES; gi++) begin : g_byte
            localparam int SLOT = gi / IN_WORDS;
            localparam int LANE = gi % IN_WORDS;
            localparam int SEG  = gi / STREAM_BYTES;

            assign byte_set[gi] = wr_fire && (wr_ptr_q == WR_WIDTH'(SLOT));
            assign byte_clr[gi] = rd_load && (rd_seg_q == seg_idx_t'(SEG));
            assign used_d[gi]   = byte_set[gi] | (used_q[gi] & ~byte_clr[gi]);
            assign buffer_d[8*gi +: 8] = byte_set[gi] ? bus.stream_in[8*LANE +: 8]
                                                      : buffer_q[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_seg_d    = rd_seg_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;

        if (wr_fire) begin
            wr_ptr_d = (wr_ptr_q == WR_WIDTH'(SB_WIDTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end

        if (rd_load) begin
            out_d       = seg_data;
            out_valid_d = 1'b1;
            rd_seg_d    = (rd_seg_q == seg_idx_t'(SEGMENTS - 1)) ? '0 : rd_seg_q + 1'b1;
        end else if (bus.stream_out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            used_q      <= '0;
            wr_ptr_q    <= '0;
            rd_seg_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            used_q      <= used_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_seg_q    <= rd_seg_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Data paths carry no reset; occupancy flags alone decide what is live.
    always_ff @(posedge clk) begin
        buffer_q <= buffer_d;
        out_q    <= out_d;
    end

    assign bus.stream_in_ready  = in_ready;
    assign bus.stream_out       = out_q;
    assign bus.stream_out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_widen_nto32.sv
// Directed bench for stream_widen_nto32: a 6-byte build and a 3-byte build
// driven with byte-counting patterns, checked beat by beat.
module tb_stream_widen_nto32;

    logic clk;
    logic rst_n;
    int   checks;
    int   passed;

    stream_widen_nto32_if #(.IN_WIDTH(48)) ifa ();
    stream_widen_nto32_if #(.IN_WIDTH(24)) ifb ();

    stream_widen_nto32 #(.IN_WORDS(6)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    stream_widen_nto32 #(.IN_WORDS(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] pattern(input int base);
        logic [255:0] p;
        for (int b = 0; b < 32; b++) p[8*b +: 8] = 8'(base + b);
        return p;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ifa.stream_in_valid = 1'b0;
        ifb.stream_in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // Drives the 6-byte DUT with bytes base+k; compares every consumed output beat.
    task automatic run_a(input int n_in, input int base, input bit rnd, input int n_out,
                         input string tag, output int got, output int lat);
        int sent = 0;
        int cyc  = 0;
        int c6   = -1;
        int fv   = -1;
        bit fire, take;
        got = 0;
        while (got < n_out && cyc < 4000) begin
            ifa.stream_in_valid  = (sent < n_in) && (!rnd || $urandom_range(0, 1) == 1);
            for (int b = 0; b < 6; b++) ifa.stream_in[8*b +: 8] = 8'(base + 6*sent + b);
            ifa.stream_out_ready = !rnd || $urandom_range(0, 1) == 1;
            fire = ifa.stream_in_valid && ifa.stream_in_ready;
            take = ifa.stream_out_valid && ifa.stream_out_ready;
            if (take) begin
                chk($sformatf("%s_beat%0d", tag, got), ifa.stream_out, pattern(base + 32*got));
                got++;
            end
            @(negedge clk);
            cyc++;
            if (fire) begin
                sent++;
                if (sent == 6) c6 = cyc;
            end
            if (ifa.stream_out_valid && fv < 0) fv = cyc;
        end
        lat = fv - c6;
        ifa.stream_in_valid = 1'b0;
    endtask

    int got, lat, sent, cyc;
    bit fire;

    initial begin
        checks = 0;
        passed = 0;
        rst_n  = 1'b0;
        ifa.stream_in = '0;  ifa.stream_in_valid = 1'b0;  ifa.stream_out_ready = 1'b0;
        ifb.stream_in = '0;  ifb.stream_in_valid = 1'b0;  ifb.stream_out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 256'(ifa.stream_in_ready), 256'(0));
        chk("rst_out_valid", 256'(ifa.stream_out_valid), 256'(0));
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_rst", 256'(ifa.stream_in_ready), 256'(1));
        @(negedge clk);

        // Continuous input, out_ready high: 16 beats -> 3 beats, latency 1 cycle
        run_a(16, 0, 1'b0, 3, "cont", got, lat);
        chk("cont_beats", 256'(got), 256'(3));
        chk("cont_latency", 256'(lat), 256'(1));
        ifa.stream_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("cont_no_flush", 256'(ifa.stream_out_valid), 256'(0));

        // Backpressure: out_ready low, input always valid -> 21 accepted
        do_reset();
        @(negedge clk);
        ifa.stream_out_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 40; c++) begin
            ifa.stream_in_valid = 1'b1;
            for (int b = 0; b < 6; b++) ifa.stream_in[8*b +: 8] = 8'(6*sent + b);
            fire = ifa.stream_in_ready;
            @(negedge clk);
            if (fire) sent++;
        end
        ifa.stream_in_valid = 1'b0;
        chk("full_accepted", 256'(sent), 256'(21));
        chk("full_in_ready", 256'(ifa.stream_in_ready), 256'(0));
        chk("full_out_valid", 256'(ifa.stream_out_valid), 256'(1));
        chk("full_out_hold", ifa.stream_out, pattern(0));

        // Random valid/ready on both sides: 960 bytes -> 30 beats
        do_reset();
        @(negedge clk);
        run_a(160, 0, 1'b1, 30, "rnd", got, lat);
        chk("rnd_beats", 256'(got), 256'(30));
        ifa.stream_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rnd_no_dup", 256'(ifa.stream_out_valid), 256'(0));

        // Reset mid-packet after 3 beats, then 6 fresh beats from 0xA0
        do_reset();
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            ifa.stream_in_valid = 1'b1;
            for (int b = 0; b < 6; b++) ifa.stream_in[8*b +: 8] = 8'(6*c + b);
            @(negedge clk);
        end
        do_reset();
        @(negedge clk);
        run_a(6, 8'hA0, 1'b0, 1, "fresh", got, lat);
        chk("fresh_beats", 256'(got), 256'(1));
        chk("fresh_byte0", 256'(ifa.stream_out[7:0]), 256'(8'hA0));

        // Back-to-back: beat 0 pending, segment 1 complete, ready rises once
        do_reset();
        @(negedge clk);
        ifa.stream_out_ready = 1'b0;
        for (int c = 0; c < 11; c++) begin
            ifa.stream_in_valid = 1'b1;
            for (int b = 0; b < 6; b++) ifa.stream_in[8*b +: 8] = 8'(6*c + b);
            @(negedge clk);
        end
        ifa.stream_in_valid = 1'b0;
        chk("b2b_pending_valid", 256'(ifa.stream_out_valid), 256'(1));
        chk("b2b_pending_data", ifa.stream_out, pattern(0));
        ifa.stream_out_ready = 1'b1;
        @(negedge clk);
        chk("b2b_next_valid", 256'(ifa.stream_out_valid), 256'(1));
        chk("b2b_next_data", ifa.stream_out, pattern(32));
        @(negedge clk);
        chk("b2b_drained", 256'(ifa.stream_out_valid), 256'(0));

        // 3-byte build: 64 beats -> 6 output beats, slot pointer wraps at 31
        do_reset();
        @(negedge clk);
        ifb.stream_out_ready = 1'b1;
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < 6 && cyc < 400) begin
            ifb.stream_in_valid = (sent < 64);
            for (int b = 0; b < 3; b++) ifb.stream_in[8*b +: 8] = 8'(3*sent + b);
            fire = ifb.stream_in_valid && ifb.stream_in_ready;
            if (ifb.stream_out_valid) begin
                chk($sformatf("w3_beat%0d", got), ifb.stream_out, pattern(32*got));
                got++;
            end
            @(negedge clk);
            cyc++;
            if (fire) sent++;
        end
        ifb.stream_in_valid = 1'b0;
        chk("w3_beats", 256'(got), 256'(6));
        chk("w3_sent", 256'(sent), 256'(64));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/stream_widen_nto32.md
Name: stream_widen_nto32

Overview:
- FIFO buffer that widens a narrow byte stream of IN_WORDS bytes per beat (default 6 bytes, 48 bits) into a 256-bit (32-byte) stream.
- Counterpart to the existing 256-to-N narrowing buffer. Used on the return path, e.g. packing layer results back onto the 256-bit memory stream.
- Fully enforces valid/ready flow control on both sides.
- Uses a 96-byte circular buffer: LCM of 32 and 6 bytes; also divisible by every legal IN_WORDS.

Parameters:
- IN_WORDS, 6, input beat width in bytes; must divide 96 and be <= 32, otherwise elaboration error.
- SB_WIDTH, 16, number of input slots in the buffer (96/IN_WORDS); calculated, do not override.
- WR_WIDTH, 4, slot-pointer width, clog2(SB_WIDTH); calculated.
- IN_WIDTH, 48, IN_WORDS*8; calculated.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- stream_in  input  IN_WIDTH  narrow input data; byte j at bits [8j+7:8j]
- stream_in_valid  input  1  input beat valid
- stream_in_ready  output  1  buffer can accept a beat this cycle
- stream_out  output  256  wide output data; byte b at bits [8b+7:8b]
- stream_out_valid  output  1  output beat valid
- stream_out_ready  input  1  downstream accepts output

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is synchronous and active-low. All state updates on posedge clk.
- Storage:
  - buffer[767:0], plus byte-occupancy flags used[95:0].
  - Input slot s covers buffer bytes [IN_WORDS*s +: IN_WORDS].
  - Output segment g (0..2) covers bytes [32*g +: 32].
- Write side:
  - stream_in_ready = rst_n && (used[IN_WORDS*wr_ptr +: IN_WORDS] == 0). Combinational from registered state only; no dependence on stream_in_valid.
  - On handshake (valid && ready), in the same edge:
    - byte j of stream_in goes to buffer byte IN_WORDS*wr_ptr+j;
    - those used bits are set;
    - wr_ptr increments, wrapping SB_WIDTH-1 -> 0.
- Read side:
  - Segment rd_seg is full when &used[32*rd_seg +: 32].
  - Output register loads when (!stream_out_valid || stream_out_ready) and the segment is full. On load:
    - stream_out <= segment data; stream_out_valid <= 1;
    - used bits of that segment are cleared;
    - rd_seg increments, wrapping 2 -> 0.
  - Otherwise, if stream_out_ready, stream_out_valid <= 0.
  - stream_out holds its value while valid && !ready.
- Latency: the handshake that completes a segment at edge n gives stream_out_valid = 1 after edge n+1.
- Throughput:
  - Input: one beat per cycle while slots are free.
  - Output: back-to-back beats when data is available.
- Straddling slots (e.g. IN_WORDS=6, slot 5 = bytes 30-35):
  - The slot is writable only when all of its bytes are free, i.e. after both touched segments have been read.
  - Clearing a segment never frees a slot partially; bits stay set until their own segment is read.
- Simultaneous write and segment clear in one cycle:
  - The byte sets are always disjoint from the byte clears, by construction.
  - Both take effect.
- Reset (rst_n = 0, any time including mid-packet):
  - used cleared, wr_ptr = 0, rd_seg = 0;
  - stream_out_valid = 0, stream_in_ready = 0;
  - stream_out is don't-care.
  - stream_in_ready rises in the first cycle after rst_n returns to 1.
  - Partially packed data is discarded.
- Full: the buffer holds at most 96 bytes plus 32 in the output register.
- Empty: stream_out_valid stays 0; no partial-beat flush (a stream must be a multiple of 32 bytes).

Decomposition:
- Package stream_pkg:
  - STREAM_BYTES = 32, BUFFER_BYTES = 96, SEGMENTS = 3;
  - function slots(in_words) = BUFFER_BYTES/in_words.
- No sub-module; the output register is inline (single file, about 150-200 lines).

Test Plan:
- Continuous input, out_ready = 1, IN_WORDS = 6, input byte k = k mod 256 → beat 0 byte0 = 0x00 and byte31 = 0x1F; beat 1 bytes 0x20..0x3F; beat 2 bytes 0x40..0x5F. The first valid follows the 6th input handshake by 1 cycle.
- out_ready held 0, input always valid → exactly 21 beats accepted, then stream_in_ready = 0 at wr_ptr = 5; stream_out holds bytes 0x00..0x1F stable.
- Random valid/ready toggling on both sides, 960 bytes → 30 output beats, byte-exact and in order; no handshake lost or duplicated.
- Reset pulse after 3 input beats, then 6 fresh beats with bytes 0xA0+ → first output byte0 = 0xA0; no stale data appears.
- IN_WORDS = 3 build, 64 beats → 6 output beats, correct bytes; slot-pointer wrap at 31 exercised.
- Single output beat pending with out_ready asserted on the same cycle the next segment completes → back-to-back valid, no bubble, correct data.
